// File: rtl/tdm_demux4.sv
// tdm_demux4: 1:4 time-division demultiplexer with sof-based framing,
// auto-resync, and optional parity check (`TDM_DEMUX_PARITY_EN).
// Ports: clk, rst_n, din/din_valid/sof/din_par in; out0..out3,
// frame_valid, sync_err, par_err, locked, frame_cnt out.
module tdm_demux4 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sof,
  input  logic             din_par,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic             frame_valid,
  output logic             sync_err,
  output logic             par_err,
  output logic             locked,
  output logic [7:0]       frame_cnt
);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t           state, state_n;
  logic [1:0]       slot, slot_n;
  logic [WIDTH-1:0] stg0, stg1, stg2;
  logic [WIDTH-1:0] stg0_n, stg1_n, stg2_n;
  logic [WIDTH-1:0] o0_n, o1_n, o2_n, o3_n;
  logic             fv_n, se_n;
  logic [7:0]       cnt_n;

  logic hunt, c_start, c_drop, c_lost;
  logic c_last, c_mid;

  // Any sof beat (re)starts a frame; the
  // remaining cases are mutually exclusive.
  assign hunt    = (state == HUNT);
  assign c_start = sof;
  assign c_drop  = !sof && hunt;
  assign c_lost  = !sof && !hunt
                   && (slot == 2'd0);
  assign c_last  = !sof && !hunt
                   && (slot == 2'd3);
  assign c_mid   = !sof && !hunt
                   && (slot == 2'd1
                   ||  slot == 2'd2);

  assign locked = (state == LOCKED);

`ifdef TDM_DEMUX_PARITY_EN
  logic stk, stk_n, pe_n, bad;
  assign bad = ^{din, din_par};
`else
  logic unused_par;
  assign unused_par = din_par;
  assign par_err    = 1'b0;
`endif

  always_comb begin
    state_n = state;
    slot_n  = slot;
    stg0_n  = stg0;
    stg1_n  = stg1;
    stg2_n  = stg2;
    o0_n    = out0;
    o1_n    = out1;
    o2_n    = out2;
    o3_n    = out3;
    fv_n    = 1'b0;
    se_n    = 1'b0;
    cnt_n   = frame_cnt;
`ifdef TDM_DEMUX_PARITY_EN
    stk_n   = stk;
    pe_n    = 1'b0;
`endif
    if (din_valid) begin
      unique case (1'b1)
        c_start: begin
          se_n    = !hunt && (slot != 2'd0);
          stg0_n  = din;
          slot_n  = 2'd1;
          state_n = LOCKED;
`ifdef TDM_DEMUX_PARITY_EN
          stk_n   = bad;
`endif
        end
        c_drop: begin
        end
        c_lost: begin
          se_n    = 1'b1;
          state_n = HUNT;
`ifdef TDM_DEMUX_PARITY_EN
          stk_n   = 1'b0;
`endif
        end
        c_last: begin
          o0_n   = stg0;
          o1_n   = stg1;
          o2_n   = stg2;
          o3_n   = din;
          fv_n   = 1'b1;
          cnt_n  = frame_cnt + 8'd1;
          slot_n = 2'd0;
`ifdef TDM_DEMUX_PARITY_EN
          pe_n   = stk | bad;
          stk_n  = 1'b0;
`endif
        end
        c_mid: begin
          if (slot == 2'd1) stg1_n = din;
          else              stg2_n = din;
          slot_n = slot + 2'd1;
`ifdef TDM_DEMUX_PARITY_EN
          stk_n  = stk | bad;
`endif
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      slot        <= 2'd0;
      stg0        <= '0;
      stg1        <= '0;
      stg2        <= '0;
      out0        <= '0;
      out1        <= '0;
      out2        <= '0;
      out3        <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      frame_cnt   <= 8'd0;
    end else begin
      state       <= state_n;
      slot        <= slot_n;
      stg0        <= stg0_n;
      stg1        <= stg1_n;
      stg2        <= stg2_n;
      out0        <= o0_n;
      out1        <= o1_n;
      out2        <= o2_n;
      out3        <= o3_n;
      frame_valid <= fv_n;
      sync_err    <= se_n;
      frame_cnt   <= cnt_n;
    end
  end

`ifdef TDM_DEMUX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stk     <= 1'b0;
      par_err <= 1'b0;
    end else begin
      stk     <= stk_n;
      par_err <= pe_n;
    end
  end
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: randomized + directed bench for tdm_demux4
// against a queue-based frame model.
module tb_tdm_demux4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid, sof, din_par;
  logic [7:0] out0, out1, out2, out3;
  logic       frame_valid, sync_err;
  logic       par_err, locked;
  logic [7:0] frame_cnt;

  tdm_demux4 #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .din(din), .din_valid(din_valid),
    .sof(sof), .din_par(din_par),
    .out0(out0), .out1(out1),
    .out2(out2), .out3(out3),
    .frame_valid(frame_valid),
    .sync_err(sync_err),
    .par_err(par_err), .locked(locked),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  bit         hunting;
  logic [7:0] fq[$];
  bit         pq[$];
  logic [7:0] e_out[4];
  logic       e_fv, e_se, e_pe;
  logic [7:0] e_cnt;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h",
             tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("out0", 32'(out0), 32'(e_out[0]));
    chk("out1", 32'(out1), 32'(e_out[1]));
    chk("out2", 32'(out2), 32'(e_out[2]));
    chk("out3", 32'(out3), 32'(e_out[3]));
    chk("frame_valid", 32'(frame_valid),
        32'(e_fv));
    chk("sync_err", 32'(sync_err), 32'(e_se));
    chk("par_err", 32'(par_err), 32'(e_pe));
    chk("locked", 32'(locked), 32'(!hunting));
    chk("frame_cnt", 32'(frame_cnt),
        32'(e_cnt));
  endtask

  task automatic model_reset();
    hunting = 1'b1;
    fq.delete();
    pq.delete();
    for (int i = 0; i < 4; i++) e_out[i] = '0;
    e_fv = 0; e_se = 0; e_pe = 0;
    e_cnt = '0;
  endtask

  task automatic model(input bit s,
                       input logic [7:0] d,
                       input bit bp);
    if (s) begin
      if (!hunting && fq.size() != 0) e_se = 1;
      fq.delete(); pq.delete();
      fq.push_back(d); pq.push_back(bp);
      hunting = 0;
    end else if (hunting) begin
    end else if (fq.size() == 0) begin
      e_se = 1;
      hunting = 1;
    end else begin
      fq.push_back(d); pq.push_back(bp);
      if (fq.size() == 4) begin
        for (int i = 0; i < 4; i++)
          e_out[i] = fq[i];
        e_fv = 1;
        e_cnt = e_cnt + 8'd1;
`ifdef TDM_DEMUX_PARITY_EN
        for (int i = 0; i < 4; i++)
          if (pq[i]) e_pe = 1;
`endif
        fq.delete(); pq.delete();
      end
    end
  endtask

  task automatic cyc(input bit v, input bit s,
                     input logic [7:0] d,
                     input bit bp);
    din_valid = v;
    sof       = s;
    din       = d;
    din_par   = (^d) ^ bp;
    @(posedge clk);
    #1;
    e_fv = 0; e_se = 0; e_pe = 0;
    if (v) model(s, d, bp);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, 8'hEE, 0);
  endtask

  task automatic frame(input logic [7:0] a, b, c, d,
                       input int gap,
                       input int badslot);
    cyc(1, 1, a, badslot == 0); idle(gap);
    cyc(1, 0, b, badslot == 1); idle(gap);
    cyc(1, 0, c, badslot == 2); idle(gap);
    cyc(1, 0, d, badslot == 3);
  endtask

  initial begin
    int k;
    bit s;
    rst_n = 0; din = 0; din_valid = 0;
    sof = 0; din_par = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1;

    frame(8'hA1, 8'hB2, 8'hC3, 8'hD4, 0, -1);
    chk("t1_out0", 32'(out0), 32'hA1);
    chk("t1_out3", 32'(out3), 32'hD4);
    chk("t1_fv", 32'(frame_valid), 32'd1);
    chk("t1_cnt", 32'(frame_cnt), 32'd1);
    idle(1);
    chk("t1_fv_pulse", 32'(frame_valid), 32'd0);

    frame(8'hA1, 8'hB2, 8'hC3, 8'hD4, 3, -1);
    chk("t2_cnt", 32'(frame_cnt), 32'd2);

    cyc(1, 1, 8'h11, 0);
    cyc(1, 0, 8'h22, 0);
    cyc(1, 1, 8'h33, 0);
    chk("t3_se", 32'(sync_err), 32'd1);
    chk("t3_hold", 32'(out0), 32'hA1);
    cyc(1, 0, 8'h44, 0);
    cyc(1, 0, 8'h55, 0);
    cyc(1, 0, 8'h66, 0);
    chk("t3_out0", 32'(out0), 32'h33);
    chk("t3_out3", 32'(out3), 32'h66);

    cyc(1, 0, 8'h77, 0);
    chk("t4_se", 32'(sync_err), 32'd1);
    chk("t4_lock", 32'(locked), 32'd0);
    cyc(1, 0, 8'h78, 0);
    cyc(1, 0, 8'h79, 0);
    cyc(1, 0, 8'h7A, 0);
    chk("t4_drop", 32'(frame_valid), 32'd0);

    frame(8'h01, 8'h02, 8'h03, 8'h04, 0, 1);
    frame(8'h05, 8'h06, 8'h07, 8'h08, 0, -1);

    for (int f = 0; f < 256; f++)
      frame(8'(f), 8'(f + 1), 8'(f + 2),
            8'(f + 3), 0, -1);
    chk("wrap_cnt", 32'(frame_cnt),
        32'(8'(e_cnt)));

    cyc(1, 1, 8'hC0, 0);
    cyc(1, 0, 8'hC1, 0);
    cyc(1, 0, 8'hC2, 0);
    rst_n = 0;
    #1;
    model_reset();
    check_all();
    chk("rst_out0", 32'(out0), 32'd0);
    chk("rst_cnt", 32'(frame_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1;
    cyc(1, 0, 8'hC3, 0);
    chk("rst_nofr", 32'(frame_valid), 32'd0);

    k = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
      end else begin
        if (k % 4 == 0)
          s = ($urandom_range(0, 9) != 0);
        else
          s = ($urandom_range(0, 19) == 0);
        cyc(1, s, 8'($urandom),
            $urandom_range(0, 9) == 0);
        k++;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
